// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS decode definitions: opcode constants, ALU operation encodings and the
// control bundle produced by the main decoder.
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] aluop;
        logic       dst_rd;   // destination is rd rather than rt
        logic       uses_rt;  // rt is a true source operand (matters for load-use)
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_main_decoder.sv
// Combinational opcode decoder: maps the 6-bit opcode to raw control signals and
// flags any unsupported opcode as illegal.
module main_decoder
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
                ctrl.dst_rd   = 1'b1;
                ctrl.uses_rt  = 1'b1;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch  = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.uses_rt = 1'b1;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage with same-cycle writeback bypass, load-use hazard detection and
// the ID/EX pipeline register feeding execute.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic              ex_flush,
    output logic [REG_AW-1:0] ra1,
    output logic [REG_AW-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dst,
    output logic [5:0]        ex_funct,
    output logic [1:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_illegal
);

    logic [5:0]        op;
    logic [REG_AW-1:0] rs, rt, rd, dec_dst;
    logic [DATA_W-1:0] opa, opb, imm_ext;
    ctrl_t             ctrl;
    logic              bubble;

    assign op      = if_instr[31:26];
    assign rs      = if_instr[25:21];
    assign rt      = if_instr[20:16];
    assign rd      = if_instr[15:11];
    assign imm_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
    assign ra1     = rs;
    assign ra2     = rt;

    main_decoder u_main_decoder (
        .op   (op),
        .ctrl (ctrl)
    );

    assign dec_dst = ctrl.dst_rd ? rd : rt;

    // register_file commits on the same edge we sample, so forward the WB value.
    always_comb begin
        opa = rd1;
        opb = rd2;
        if (rs == '0) begin
            opa = '0;
        end else if (wb_regwrite && wb_wa == rs) begin
            opa = wb_wd;
        end
        if (rt == '0) begin
            opb = '0;
        end else if (wb_regwrite && wb_wa == rt) begin
            opb = wb_wd;
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!ex_flush && if_valid && ex_valid && ex_memread && ex_dst != '0) begin
            stall = (ex_dst == rs) || (ctrl.uses_rt && ex_dst == rt);
        end
    end

    assign bubble = ex_flush | stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_aluop    <= '0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_aluop    <= '0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else begin
            ex_valid    <= if_valid;
            ex_aluop    <= if_valid ? ctrl.aluop : '0;
            ex_alusrc   <= if_valid & ctrl.alusrc;
            ex_regwrite <= if_valid & ctrl.regwrite & (dec_dst != '0);
            ex_memread  <= if_valid & ctrl.memread;
            ex_memwrite <= if_valid & ctrl.memwrite;
            ex_branch   <= if_valid & ctrl.branch;
            ex_illegal  <= if_valid & ctrl.illegal;
        end
    end

    // Data fields simply hold across a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc4   <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_dst   <= '0;
            ex_funct <= '0;
        end else if (!bubble) begin
            ex_pc4   <= if_pc4;
            ex_a     <= opa;
            ex_b     <= opb;
            ex_imm   <= imm_ext;
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_dst   <= dec_dst;
            ex_funct <= if_instr[5:0];
        end
    end

endmodule
